if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode/controller stage. Holds the PC and fetches 32-bit instructions over a variable-latency instruction-memory handshake.
- Buffers fetched words in a 2-entry FIFO and presents them to decode, which slices op/funct from the instruction.
- Accepts branch/jump redirects from downstream and flushes wrong-path instructions.

---
 rtl/if_fetch_stage.sv | 175 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one non-abortable request at a
// time to instruction memory, buffers responses in a 2-entry FIFO for decode,
// and handles branch/jump redirects by flushing and discarding wrong-path data.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_valid_i,
    input  logic        pcsrc_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;
    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   fetch_pc_n;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_addr_n;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic [CNT_W-1:0]  cnt_after_pop;
    logic [XLEN-1:0]   tail_instr;
    logic [XLEN-1:0]   tail_pc4;
    logic              req_n;
    logic              push;
    logic              pop;
    logic              flush;
    logic              redirect;
    logic [XLEN-1:0]   raw_target;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   resp_next;

    assign imem_addr_o = req_addr;

    // Redirect decode: branch wins over jump, targets are word aligned.
    always_comb begin
        redirect   = pcsrc_i | jump_i;
        raw_target = pcsrc_i ? branch_target_i : jump_target_i;
        target     = {raw_target[XLEN-1:2], 2'b00};
        pop        = instr_valid_o & instr_ready_i;
        resp_next  = req_addr + WORD_BYTES;
        cnt_after_pop = count - CNT_W'(pop);
    end

    // Next-state, next-PC, issue address and FIFO push/flush control.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_addr_n = req_addr;
        push       = 1'b0;
        flush      = 1'b0;

        if (redirect) begin
            flush      = 1'b1;
            fetch_pc_n = target;
        end

        case (state)
            IDLE: begin
                state_n    = FETCH;
                req_addr_n = redirect ? target : fetch_pc;
            end
            FETCH: begin
                if (redirect) begin
                    // Old request still in flight must be completed, so drain it in DROP.
                    if (imem_valid_i) begin
                        req_addr_n = target;
                    end else begin
                        state_n = DROP;
                    end
                end else if (imem_valid_i) begin
                    push       = 1'b1;
                    fetch_pc_n = resp_next;
                    if (cnt_after_pop == (DEPTH - CNT_W'(1))) begin
                        state_n = FULL;
                    end else begin
                        req_addr_n = resp_next;
                    end
                end
            end
            FULL: begin
                if (redirect) begin
                    state_n    = FETCH;
                    req_addr_n = target;
                end else if (pop) begin
                    state_n    = FETCH;
                    req_addr_n = fetch_pc;
                end
            end
            DROP: begin
                // Discard the wrong-path response; a redirect arriving with it is honoured directly.
                if (imem_valid_i) begin
                    state_n    = FETCH;
                    req_addr_n = redirect ? target : fetch_pc;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (flush) begin
            count_n = '0;
        end else begin
            count_n = cnt_after_pop + CNT_W'(push);
        end
        req_n = (state_n == FETCH) || (state_n == DROP);
    end

    // Control registers: state, PCs, request and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            fetch_pc      <= RESET_PC;
            req_addr      <= '0;
            count         <= '0;
            imem_req_o    <= 1'b0;
            instr_valid_o <= 1'b0;
        end else begin
            state         <= state_n;
            fetch_pc      <= fetch_pc_n;
            req_addr      <= req_addr_n;
            count         <= count_n;
            imem_req_o    <= req_n;
            instr_valid_o <= (count_n != '0);
        end
    end

    // Shift FIFO storage: slot 0 is the head and drives decode directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_o    <= '0;
            pc_plus4_o <= '0;
            tail_instr <= '0;
            tail_pc4   <= '0;
        end else if (!flush) begin
            if (pop) begin
                instr_o    <= tail_instr;
                pc_plus4_o <= tail_pc4;
            end
            if (push) begin
                if (cnt_after_pop == '0) begin
                    instr_o    <= imem_rdata_i;
                    pc_plus4_o <= resp_next;
                end else begin
                    tail_instr <= imem_rdata_i;
                    tail_pc4   <= resp_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: latency-configurable memory model, scoreboard of
// expected instruction addresses, a redirect vector table and corner sequences.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        pcsrc = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] jump_target = '0;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        ready = 1'b0;

    // Wrap DUT (RESET_PC = FFFF_FFFC), zero-latency memory
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic        w_valid;

    int          mem_lat = 0;
    int          wait_cnt;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] sb[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory answers once the request has waited mem_lat cycles.
    assign mem_valid = mem_req && (wait_cnt >= mem_lat);
    assign mem_rdata = mem_valid ? word_at(mem_addr) : 32'hBAD0_BAD0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       wait_cnt <= 0;
        else if (mem_req && !mem_valid) wait_cnt <= wait_cnt + 1;
        else                           wait_cnt <= 0;
    end

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(mem_req), .imem_addr_o(mem_addr),
        .imem_rdata_i(mem_rdata), .imem_valid_i(mem_valid),
        .pcsrc_i(pcsrc), .branch_target_i(branch_target),
        .jump_i(jump), .jump_target_i(jump_target),
        .instr_o(instr), .pc_plus4_o(pc_plus4),
        .instr_valid_o(instr_valid), .instr_ready_i(ready)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_rdata_i(w_addr), .imem_valid_i(w_req),
        .pcsrc_i(1'b0), .branch_target_i(32'h0),
        .jump_i(1'b0), .jump_target_i(32'h0),
        .instr_o(w_instr), .pc_plus4_o(w_pc4),
        .instr_valid_o(w_valid), .instr_ready_i(1'b1)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: score an accepted head, then enforce request stability.
    task automatic tick();
        logic        pend;
        logic [31:0] paddr;
        logic [31:0] e;
        if (!rst && instr_valid && ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc_plus4 %h expected none", pc_plus4);
            end else begin
                e = sb.pop_front();
                check32("sb_instr", instr, word_at(e));
                check32("sb_pc4", pc_plus4, e + 32'd4);
            end
        end
        pend  = !rst && mem_req && !mem_valid;
        paddr = mem_addr;
        @(posedge clk);
        #1;
        if (pend && !rst) begin
            check32("req_hold", 32'(mem_req), 32'd1);
            check32("addr_hold", mem_addr, paddr);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check32("rst_req", 32'(mem_req), 32'd0);
        check32("rst_addr", mem_addr, 32'd0);
        check32("rst_instr", instr, 32'd0);
        check32("rst_pc4", pc_plus4, 32'd0);
        check32("rst_valid", 32'(instr_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
    endtask

    task automatic wait_addr(input string name, input logic [31:0] a, input int bound);
        int n = 0;
        while (!(mem_req && mem_addr == a) && n < bound) begin
            tick();
            n++;
        end
        check32(name, mem_addr, a);
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check32(name, 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        logic        pcsrc;
        logic [31:0] bt;
        logic        jump;
        logic [31:0] jt;
        logic [31:0] exp_addr;
    } redir_t;

    redir_t vec[5];

    initial begin
        vec[0] = '{1'b1, 32'h0000_0080, 1'b1, 32'h0000_0100, 32'h0000_0080};
        vec[1] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0103, 32'h0000_0100};
        vec[2] = '{1'b1, 32'h0000_0203, 1'b0, 32'h0000_0300, 32'h0000_0200};
        vec[3] = '{1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vec[4] = '{1'b1, 32'h0000_0044, 1'b0, 32'h0000_0000, 32'h0000_0044};

        // Zero latency streaming, plus the wrapping reset PC instance
        mem_lat = 0;
        ready   = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) sb.push_back(32'(i * 4));
        tick();
        check32("t1_req", 32'(mem_req), 32'd1);
        check32("t1_addr0", mem_addr, 32'd0);
        check32("t1_nvalid", 32'(instr_valid), 32'd0);
        check32("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        tick();
        check32("t1_valid", 32'(instr_valid), 32'd1);
        check32("t1_addr4", mem_addr, 32'd4);
        check32("wrap_addr1", w_addr, 32'd0);
        check32("wrap_pc4", w_pc4, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check32("t1_seq", mem_addr, 32'(8 + 4 * k));
        end
        drain("t1_drain", 40);

        // Slow memory with decode stalled fills the FIFO and stops requesting
        mem_lat = 3;
        ready   = 1'b0;
        do_reset();
        repeat (20) tick();
        check32("t2_req_off", 32'(mem_req), 32'd0);
        check32("t2_valid", 32'(instr_valid), 32'd1);
        check32("t2_head", instr, word_at(32'd0));
        check32("t2_pc4", pc_plus4, 32'd4);
        for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
        ready = 1'b1;
        tick();
        check32("t2_resume_req", 32'(mem_req), 32'd1);
        check32("t2_resume_addr", mem_addr, 32'd8);
        drain("t2_drain", 60);

        // Branch while a request is outstanding: old data dropped
        mem_lat = 3;
        ready   = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
        wait_addr("t3_reach_10", 32'h10, 40);
        pcsrc         = 1'b1;
        branch_target = 32'h40;
        tick();
        pcsrc = 1'b0;
        check32("t3_drop_req", 32'(mem_req), 32'd1);
        check32("t3_drop_addr", mem_addr, 32'h10);
        check32("t3_flushed", 32'(instr_valid), 32'd0);
        sb.delete();
        sb.push_back(32'h40);
        sb.push_back(32'h44);
        wait_addr("t3_next_40", 32'h40, 20);
        drain("t3_drain", 40);

        // Redirect vector table on a zero-latency stream with decode popping
        mem_lat = 0;
        ready   = 1'b1;
        do_reset();
        sb.push_back(32'd0);
        sb.push_back(32'd4);
        sb.push_back(32'd8);
        repeat (4) tick();
        for (int v = 0; v < 5; v++) begin
            pcsrc         = vec[v].pcsrc;
            branch_target = vec[v].bt;
            jump          = vec[v].jump;
            jump_target   = vec[v].jt;
            tick();
            pcsrc = 1'b0;
            jump  = 1'b0;
            check32("vec_req", 32'(mem_req), 32'd1);
            check32("vec_addr", mem_addr, vec[v].exp_addr);
            check32("vec_flush", 32'(instr_valid), 32'd0);
            for (int k = 0; k < 3; k++) sb.push_back(vec[v].exp_addr + 32'(4 * k));
            repeat (3) tick();
        end
        tick();
        check32("vec_drain", 32'(sb.size()), 32'd0);

        // Reset asserted while draining in DROP
        mem_lat = 5;
        ready   = 1'b1;
        do_reset();
        tick();
        jump        = 1'b1;
        jump_target = 32'h100;
        tick();
        jump = 1'b0;
        check32("t6_drop_addr", mem_addr, 32'd0);
        check32("t6_drop_req", 32'(mem_req), 32'd1);
        tick();
        mem_lat = 0;
        do_reset();
        sb.push_back(32'd0);
        sb.push_back(32'd4);
        tick();
        check32("t6_restart_req", 32'(mem_req), 32'd1);
        check32("t6_restart_addr", mem_addr, 32'd0);
        drain("t6_drain", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
